// File: rtl/fechadura_pkg.sv
// Shared definitions for the keypad front-end of the sequential lock.
package fechadura_pkg;

  localparam int DIGITO_W  = 4;
  localparam int N_DIGITOS = 4;

  // Password loaded on reset; the top nibble is the first digit keyed.
  localparam logic [DIGITO_W*N_DIGITOS-1:0] SENHA_PADRAO = 16'h4952;

  typedef enum logic [1:0] {
    SOLTO,
    CONF_PRESS,
    PRESSIONADO,
    CONF_SOLTA
  } deb_state_e;

  // True for 0..9; keys A..F are never a valid password digit.
  function automatic logic eh_bcd(input logic [DIGITO_W-1:0] d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/entrada_teclado_if.sv
// Keypad/lock bus: button, key, lock progress and password programming.
interface entrada_teclado_if;
  import fechadura_pkg::*;

  logic                          btn_raw;
  logic [DIGITO_W-1:0]           tecla;
  logic [1:0]                    s;
  logic                          u;
  logic                          prog_we;
  logic [DIGITO_W*N_DIGITOS-1:0] prog_senha;
  logic                          p;
  logic                          c;
  logic                          prog_ok;

  // Lock / keypad side driving the front-end.
  modport master (
    output btn_raw, tecla, s, u, prog_we, prog_senha,
    input  p, c, prog_ok
  );

  // The keypad front-end itself.
  modport slave (
    input  btn_raw, tecla, s, u, prog_we, prog_senha,
    output p, c, prog_ok
  );
endinterface

// File: rtl/entrada_teclado_debouncer_botao.sv
// Button synchroniser + debounce FSM; also synchronises the key code so the
// digit latch sees a value aligned with the debounced button.
module debouncer_botao
  import fechadura_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btn_raw_i,
  input  logic [DIGITO_W-1:0] tecla_i,
  output logic                p_o,
  output logic                aceita_o,
  output logic                solto_o,
  output logic [DIGITO_W-1:0] tecla_s_o
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  // Entry into a confirm state is the first stable sample, so the exit
  // fires DEBOUNCE_CYCLES-2 increments later (DEBOUNCE_CYCLES stable edges).
  localparam logic [CNT_W-1:0] CNT_ALVO = CNT_W'(DEBOUNCE_CYCLES - 2);

  logic [1:0]                btn_sync_q;
  logic [1:0][DIGITO_W-1:0]  tecla_sync_q;
  logic [1:0]                vld_pipe_q;
  logic                      armado_q;
  deb_state_e                state_q;
  logic [CNT_W-1:0]          cnt_q;
  logic                      p_q;
  logic                      btn_s;

  assign btn_s     = btn_sync_q[1];
  assign tecla_s_o = tecla_sync_q[1];
  assign p_o       = p_q;
  assign solto_o   = (state_q == SOLTO);
  assign aceita_o  = (state_q == CONF_PRESS) && btn_s && (cnt_q == CNT_ALVO);

  // Two-flop synchronisers; vld_pipe marks when btn_s reflects the real pin.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_sync_q   <= '0;
      tecla_sync_q <= '0;
      vld_pipe_q   <= '0;
    end else begin
      btn_sync_q   <= {btn_sync_q[0], btn_raw_i};
      tecla_sync_q <= {tecla_sync_q[0], tecla_i};
      vld_pipe_q   <= {vld_pipe_q[0], 1'b1};
    end
  end

  // Arm only after a real released level is seen, so a button still held
  // through reset cannot produce a press until it is let go.
  always_ff @(posedge clk) begin
    if (reset)                        armado_q <= 1'b0;
    else if (vld_pipe_q[1] && !btn_s) armado_q <= 1'b1;
  end

  // Debounce FSM with saturating stability counter and registered p.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SOLTO;
      cnt_q   <= '0;
      p_q     <= 1'b0;
    end else begin
      case (state_q)
        SOLTO: begin
          p_q <= 1'b0;
          if (armado_q && btn_s) begin
            state_q <= CONF_PRESS;
            cnt_q   <= '0;
          end
        end
        CONF_PRESS: begin
          if (!btn_s) state_q <= SOLTO;
          else if (cnt_q == CNT_ALVO) begin
            state_q <= PRESSIONADO;
            p_q     <= 1'b1;
          end else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
        end
        PRESSIONADO: begin
          p_q <= 1'b1;
          if (!btn_s) begin
            state_q <= CONF_SOLTA;
            cnt_q   <= '0;
          end
        end
        CONF_SOLTA: begin
          if (btn_s) state_q <= PRESSIONADO;
          else if (cnt_q == CNT_ALVO) begin
            state_q <= SOLTO;
            p_q     <= 1'b0;
          end else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
        end
        default: begin
          state_q <= SOLTO;
          p_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/entrada_teclado.sv
// Keypad front-end: debounced press, digit latch, password compare and
// password reprogramming while the lock is open.
module entrada_teclado #(
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter logic [15:0] SENHA_PADRAO    = fechadura_pkg::SENHA_PADRAO
) (
  input  logic             clk,
  input  logic             reset,
  entrada_teclado_if.slave bus
);
  import fechadura_pkg::*;

  logic                          p;
  logic                          aceita;
  logic                          solto;
  logic [DIGITO_W-1:0]           tecla_s;
  logic [DIGITO_W-1:0]           digito_q;
  logic [DIGITO_W*N_DIGITOS-1:0] senha_q;
  logic                          prog_ok_q;
  logic                          prog_ok_d;
  logic                          prog_bcd;
  logic [DIGITO_W-1:0]           esperado;

  debouncer_botao #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_deb (
    .clk       (clk),
    .reset     (reset),
    .btn_raw_i (bus.btn_raw),
    .tecla_i   (bus.tecla),
    .p_o       (p),
    .aceita_o  (aceita),
    .solto_o   (solto),
    .tecla_s_o (tecla_s)
  );

  // Select the password digit awaited by the lock (digit 0 is the top nibble).
  always_comb begin
    esperado = '0;
    for (int i = 0; i < N_DIGITOS; i++)
      if (bus.s == 2'(i)) esperado = senha_q[(N_DIGITOS-1-i)*DIGITO_W +: DIGITO_W];
  end

  // A new password must be all-BCD, or the lock could never be opened again.
  always_comb begin
    prog_bcd = 1'b1;
    for (int i = 0; i < N_DIGITOS; i++)
      if (!eh_bcd(bus.prog_senha[i*DIGITO_W +: DIGITO_W])) prog_bcd = 1'b0;
  end

  assign prog_ok_d = bus.prog_we && bus.u && solto && prog_bcd;

  // Capture the key on the same edge that p rises.
  always_ff @(posedge clk) begin
    if (reset)       digito_q <= '0;
    else if (aceita) digito_q <= tecla_s;
  end

  // Password register and write-accept pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      senha_q   <= SENHA_PADRAO;
      prog_ok_q <= 1'b0;
    end else begin
      prog_ok_q <= prog_ok_d;
      if (prog_ok_d) senha_q <= bus.prog_senha;
    end
  end

  assign bus.p       = p;
  assign bus.c       = p && eh_bcd(digito_q) && (digito_q == esperado);
  assign bus.prog_ok = prog_ok_q;

endmodule

// File: tb/tb_entrada_teclado.sv
// Directed bench for entrada_teclado with a tiny sequential-lock model.
module tb_entrada_teclado;
  localparam int D = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  entrada_teclado_if bus();

  entrada_teclado #(
    .DEBOUNCE_CYCLES (D),
    .SENHA_PADRAO    (16'h4952)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic err_m;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Press key k cleanly; report c at the cycle p rises and whether p rose/fell.
  task automatic press(input logic [3:0] k, output logic c_at, output logic ok);
    bus.tecla = k;
    tick; tick;
    bus.btn_raw = 1'b1;
    ok = 1'b0; c_at = 1'b0;
    for (int i = 0; i < D + 10; i++) begin
      tick;
      if (bus.p === 1'b1) begin ok = 1'b1; c_at = bus.c; break; end
    end
    bus.btn_raw = 1'b0;
    if (ok) begin
      ok = 1'b0;
      for (int i = 0; i < D + 10; i++) begin
        tick;
        if (bus.p === 1'b0) begin ok = 1'b1; break; end
      end
    end
  endtask

  // One keystroke into the lock model: advance on c, latch error otherwise.
  task automatic lock_key(input logic [3:0] k);
    logic c_at, ok;
    press(k, c_at, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL lock_press_timeout key=%h", k); end
    if (!err_m) begin
      if (c_at) begin
        if (bus.s == 2'd3) bus.u = 1'b1;
        else bus.s = bus.s + 2'd1;
      end else err_m = 1'b1;
    end
  endtask

  task automatic lock_clear;
    bus.s = 2'd0; bus.u = 1'b0; err_m = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.btn_raw = 1'b0; bus.tecla = 4'd0; bus.s = 2'd0; bus.u = 1'b0;
    bus.prog_we = 1'b0; bus.prog_senha = 16'h0000; err_m = 1'b0;
    tick; tick;
    n_tests++; if (bus.p !== 1'b0) begin n_fail++; $display("FAIL reset_p got=%b exp=0", bus.p); end
    n_tests++; if (bus.c !== 1'b0) begin n_fail++; $display("FAIL reset_c got=%b exp=0", bus.c); end
    n_tests++; if (bus.prog_ok !== 1'b0) begin n_fail++; $display("FAIL reset_prog_ok got=%b exp=0", bus.prog_ok); end
    n_tests++; if (dut.senha_q !== 16'h4952) begin n_fail++; $display("FAIL reset_senha got=%h exp=4952", dut.senha_q); end
    reset = 1'b0;
    tick; tick; tick; tick;
  endtask

  task automatic test_bounce;
    logic [4:0] pat;
    logic p_seen, prev;
    int rises;
    pat = 5'b10110;
    p_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.btn_raw = pat[4-i];
      tick;
      if (bus.p !== 1'b0) p_seen = 1'b1;
    end
    bus.btn_raw = 1'b0;
    for (int i = 0; i < 4; i++) begin tick; if (bus.p !== 1'b0) p_seen = 1'b1; end
    n_tests++; if (p_seen) begin n_fail++; $display("FAIL bounce_no_p got=1 exp=0"); end
    // btn_raw rises before edge N.
    bus.btn_raw = 1'b1;
    for (int i = 0; i < 5; i++) tick;
    n_tests++; if (bus.p !== 1'b0) begin n_fail++; $display("FAIL press_lat_N4 got=%b exp=0", bus.p); end
    tick;
    n_tests++; if (bus.p !== 1'b1) begin n_fail++; $display("FAIL press_lat_N5 got=%b exp=1", bus.p); end
    rises = 0; prev = bus.p;
    for (int i = 0; i < 3; i++) begin tick; if (bus.p === 1'b1 && prev === 1'b0) rises++; prev = bus.p; end
    // Release bounce 0,1 then stable 0 before edge M.
    bus.btn_raw = 1'b0; tick; if (bus.p === 1'b1 && prev === 1'b0) rises++; prev = bus.p;
    bus.btn_raw = 1'b1; tick; if (bus.p === 1'b1 && prev === 1'b0) rises++; prev = bus.p;
    bus.btn_raw = 1'b0;
    for (int i = 0; i < D + 1; i++) begin tick; if (bus.p === 1'b1 && prev === 1'b0) rises++; prev = bus.p; end
    n_tests++; if (bus.p !== 1'b1) begin n_fail++; $display("FAIL release_lat_M4 got=%b exp=1", bus.p); end
    tick;
    n_tests++; if (bus.p !== 1'b0) begin n_fail++; $display("FAIL release_lat_M5 got=%b exp=0", bus.p); end
    for (int i = 0; i < 8; i++) begin tick; if (bus.p === 1'b1 && prev === 1'b0) rises++; prev = bus.p; end
    n_tests++; if (rises != 0) begin n_fail++; $display("FAIL one_interval extra_rises=%0d exp=0", rises); end
  endtask

  task automatic test_compare;
    logic [3:0] keys [4];
    logic [1:0] ss   [4];
    logic       expc [4];
    logic c_at, ok;
    keys = '{4'd4, 4'd5, 4'hA, 4'd2};
    ss   = '{2'd0, 2'd0, 2'd0, 2'd3};
    expc = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      bus.s = ss[i];
      press(keys[i], c_at, ok);
      n_tests++;
      if (!ok || c_at !== expc[i]) begin
        n_fail++;
        $display("FAIL compare key=%h s=%0d got_c=%b ok=%b exp_c=%b", keys[i], ss[i], c_at, ok, expc[i]);
      end
    end
    bus.s = 2'd0;
  endtask

  task automatic test_lock;
    lock_clear;
    lock_key(4'd4); lock_key(4'd9); lock_key(4'd5); lock_key(4'd2);
    n_tests++; if (bus.u !== 1'b1 || err_m) begin n_fail++; $display("FAIL lock_open got_u=%b err=%b exp_u=1", bus.u, err_m); end
    lock_clear;
    lock_key(4'd4); lock_key(4'd9); lock_key(4'd5); lock_key(4'd1);
    n_tests++; if (bus.u !== 1'b0 || !err_m) begin n_fail++; $display("FAIL lock_wrong got_u=%b err=%b exp_u=0 err=1", bus.u, err_m); end
    lock_clear;
  endtask

  task automatic test_prog;
    // Locked: request ignored.
    bus.u = 1'b0; bus.prog_we = 1'b1; bus.prog_senha = 16'h1234;
    tick; bus.prog_we = 1'b0;
    n_tests++; if (bus.prog_ok !== 1'b0) begin n_fail++; $display("FAIL prog_locked_ok got=%b exp=0", bus.prog_ok); end
    tick;
    n_tests++; if (dut.senha_q !== 16'h4952) begin n_fail++; $display("FAIL prog_locked_senha got=%h exp=4952", dut.senha_q); end
    // Unlocked: accepted, one-cycle pulse.
    bus.u = 1'b1; bus.prog_we = 1'b1; bus.prog_senha = 16'h1234;
    tick; bus.prog_we = 1'b0;
    n_tests++; if (bus.prog_ok !== 1'b1) begin n_fail++; $display("FAIL prog_ok_pulse got=%b exp=1", bus.prog_ok); end
    n_tests++; if (dut.senha_q !== 16'h1234) begin n_fail++; $display("FAIL prog_senha got=%h exp=1234", dut.senha_q); end
    tick;
    n_tests++; if (bus.prog_ok !== 1'b0) begin n_fail++; $display("FAIL prog_ok_width got=%b exp=0", bus.prog_ok); end
    lock_clear;
    lock_key(4'd1); lock_key(4'd2); lock_key(4'd3); lock_key(4'd4);
    n_tests++; if (bus.u !== 1'b1 || err_m) begin n_fail++; $display("FAIL prog_new_code got_u=%b err=%b exp_u=1", bus.u, err_m); end
    // Non-BCD password rejected.
    bus.prog_we = 1'b1; bus.prog_senha = 16'h12A4;
    tick; bus.prog_we = 1'b0;
    n_tests++; if (bus.prog_ok !== 1'b0) begin n_fail++; $display("FAIL prog_nonbcd_ok got=%b exp=0", bus.prog_ok); end
    tick;
    n_tests++; if (dut.senha_q !== 16'h1234) begin n_fail++; $display("FAIL prog_nonbcd_senha got=%h exp=1234", dut.senha_q); end
    lock_clear;
  endtask

  task automatic test_reset_mid;
    logic ok, c_at, p_seen;
    bus.s = 2'd0; bus.tecla = 4'd1;
    tick; tick;
    bus.btn_raw = 1'b1; ok = 1'b0;
    for (int i = 0; i < D + 10; i++) begin tick; if (bus.p === 1'b1) begin ok = 1'b1; break; end end
    n_tests++; if (!ok) begin n_fail++; $display("FAIL rmid_press_timeout"); end
    reset = 1'b1; tick; reset = 1'b0;
    n_tests++; if (bus.p !== 1'b0 || bus.c !== 1'b0) begin n_fail++; $display("FAIL rmid_outputs got_p=%b c=%b exp=0", bus.p, bus.c); end
    p_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin tick; if (bus.p !== 1'b0) p_seen = 1'b1; end
    n_tests++; if (p_seen) begin n_fail++; $display("FAIL rmid_held_no_p got=1 exp=0"); end
    bus.btn_raw = 1'b0;
    for (int i = 0; i < 10; i++) tick;
    press(4'd4, c_at, ok);
    n_tests++; if (!ok || c_at !== 1'b1) begin n_fail++; $display("FAIL rmid_repress ok=%b got_c=%b exp_c=1", ok, c_at); end
  endtask

  initial begin
    test_reset;
    test_bounce;
    test_compare;
    test_lock;
    test_prog;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
